nn_argmax: RTL

- Downstream classifier stage for NeuralNetwork: consumes the packed OUT_SIZE x IEEE-754 single-precision `result` vector and reports the index of the largest score, i.e. the predicted class.
- Sequential scan: one comparison per clock, so the block needs only a single float comparator.
- Start/busy/done handshake.
- Latches its input on start, so the upstream network may change `result` during the scan.

---
 rtl/nn_argmax.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nn_argmax.sv
// Argmax over a packed vector of IEEE-754 single-precision scores.
// One float comparison per clock; the input vector is captured on start.
//
// state   | meaning
// IDLE    | waiting for start; outputs hold the last result
// SCAN    | comparing element i against the running best
// DONE    | commit cycle; done pulses and results update on the edge leaving it
module nn_argmax #(
    parameter int OUT_SIZE = 10,
    parameter int IDX_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [32*OUT_SIZE-1:0] result_in,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      class_idx,
    output logic [31:0]           class_val,
    output logic                  all_nan
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_SIZE - 1);

    logic [1:0]              state_q, state_d;
    logic [32*OUT_SIZE-1:0]  vec_q, vec_d;
    logic [31:0]             best_val_q, best_val_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic [IDX_W-1:0]        i_q, i_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [IDX_W-1:0]        class_idx_q, class_idx_d;
    logic [31:0]             class_val_q, class_val_d;
    logic                    all_nan_q, all_nan_d;
    logic [31:0]             cand;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Strict "greater than" on raw float bits; equal values never win, so ties keep the lower index.
    function automatic logic wins(input logic [31:0] c, input logic [31:0] b);
        if (is_nan(c))
            return 1'b0;
        if (is_nan(b))
            return 1'b1;
        if ((c[30:0] == 31'd0) && (b[30:0] == 31'd0))
            return 1'b0;
        if (c[31] != b[31])
            return ~c[31];
        if (!c[31])
            return c[30:0] > b[30:0];
        return c[30:0] < b[30:0];
    endfunction

    assign cand = vec_q[32*int'(i_q) +: 32];

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        i_d         = i_q;
        done_d      = 1'b0;
        class_idx_d = class_idx_q;
        class_val_d = class_val_q;
        all_nan_d   = all_nan_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d      = result_in;
                    best_val_d = result_in[31:0];
                    best_idx_d = '0;
                    i_d        = IDX_W'(1);
                    state_d    = (OUT_SIZE == 1) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (wins(cand, best_val_q)) begin
                    best_val_d = cand;
                    best_idx_d = i_q;
                end
                i_d = i_q + IDX_W'(1);
                if (i_q == LAST_IDX)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d      = 1'b1;
                class_idx_d = best_idx_q;
                class_val_d = best_val_q;
                // A NaN best only survives when no element was a number.
                all_nan_d   = is_nan(best_val_q);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            i_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            class_idx_q <= '0;
            class_val_q <= '0;
            all_nan_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            i_q         <= i_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            class_idx_q <= class_idx_d;
            class_val_q <= class_val_d;
            all_nan_q   <= all_nan_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign class_idx = class_idx_q;
    assign class_val = class_val_q;
    assign all_nan   = all_nan_q;

endmodule
